output_collector: RTL and testbench

Downstream stage of the systolic array: captures the skewed per-column results leaving the bottom edge of the array, de-skews them into complete rows, and buffers those rows in a small FIFO. The consumer (writeback/result memory) drains rows over a valid/ready handshake. It is the output-side counterpart of the skewed input feed: column j of a row arrives j cycles after column 0.

---
 rtl/output_collector.sv | 125 ++++++++++++
 tb/tb_output_collector.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/output_collector.sv
// Bottom-edge collector for the systolic array: de-skews per-column results into
// complete rows and buffers them in a DEPTH-row FIFO drained over valid/ready.
module output_collector #(
  parameter int MATRIX_SIZE = 2,
  parameter int DATA_SIZE   = 32,
  parameter int DEPTH       = 4
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  enable,
  input  logic                                  in_valid,
  input  logic [MATRIX_SIZE-1:0][DATA_SIZE-1:0] data_in,
  output logic [MATRIX_SIZE-1:0][DATA_SIZE-1:0] out_data,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [$clog2(DEPTH):0]                count,
  output logic                                  overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  typedef logic [MATRIX_SIZE-1:0][DATA_SIZE-1:0] row_t;

  row_t aligned;
  logic aligned_valid;

  // Valid token ages alongside the data; it reaches the end when all columns line up.
  if (MATRIX_SIZE == 1) begin : g_noskew
    assign aligned_valid = in_valid;
  end else begin : g_skew
    logic [MATRIX_SIZE-2:0] vpipe;

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        vpipe <= '0;
      end else if (!enable) begin
        vpipe <= '0;
      end else begin
        vpipe[0] <= in_valid;
        for (int unsigned k = 1; k < MATRIX_SIZE - 1; k++) begin
          vpipe[k] <= vpipe[k-1];
        end
      end
    end

    assign aligned_valid = vpipe[MATRIX_SIZE-2];
  end

  // Column j is late by j cycles, so it needs MATRIX_SIZE-1-j stages of delay.
  for (genvar j = 0; j < MATRIX_SIZE; j++) begin : g_col
    if (j == MATRIX_SIZE - 1) begin : g_direct
      assign aligned[j] = data_in[j];
    end else begin : g_dly
      logic [DATA_SIZE-1:0] dly [MATRIX_SIZE-1-j];

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          for (int unsigned k = 0; k < MATRIX_SIZE - 1 - j; k++) dly[k] <= '0;
        end else if (!enable) begin
          for (int unsigned k = 0; k < MATRIX_SIZE - 1 - j; k++) dly[k] <= '0;
        end else begin
          dly[0] <= data_in[j];
          for (int unsigned k = 1; k < MATRIX_SIZE - 1 - j; k++) begin
            dly[k] <= dly[k-1];
          end
        end
      end

      assign aligned[j] = dly[MATRIX_SIZE-2-j];
    end
  end

  row_t          mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push;
  logic          pop;
  logic          full;
  logic [CW-1:0] count_next;

  always_comb begin
    pop        = out_valid && out_ready;
    full       = (count == FULL_COUNT);
    // A full FIFO still accepts a row when the head leaves in the same cycle.
    push       = aligned_valid && (!full || pop);
    count_next = count;
    if (push && !pop) count_next = count + CW'(1);
    else if (pop && !push) count_next = count - CW'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      out_valid <= 1'b0;
      overflow  <= 1'b0;
    end else if (!enable) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      out_valid <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= aligned;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      if (aligned_valid && !push) overflow <= 1'b1;
      count     <= count_next;
      out_valid <= (count_next != '0);
    end
  end

  always_comb begin
    out_data = '0;
    if (out_valid) out_data = mem[rd_ptr];
  end

endmodule

// File: tb/tb_output_collector.sv
// Scoreboard bench for output_collector: skewed rows in, queue-based FIFO model out.
module tb_output_collector;

  localparam int M  = 2;
  localparam int DW = 32;
  localparam int DP = 4;

  typedef logic [M-1:0][DW-1:0] row_t;
  typedef struct {
    int   ac;
    row_t r;
  } tok_t;

  logic                  clk = 1'b0;
  logic                  reset = 1'b0;
  logic                  enable = 1'b1;
  logic                  in_valid = 1'b0;
  row_t                  data_in = '0;
  row_t                  out_data;
  logic                  out_valid;
  logic                  out_ready = 1'b0;
  logic [$clog2(DP):0]   count;
  logic                  overflow;

  output_collector #(.MATRIX_SIZE(M), .DATA_SIZE(DW), .DEPTH(DP)) dut (
    .clk(clk), .reset(reset), .enable(enable), .in_valid(in_valid),
    .data_in(data_in), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .count(count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;

  row_t issued [int];
  tok_t pending [$];
  row_t mq [$];
  logic movf = 1'b0;

  function automatic row_t mk(input logic [DW-1:0] a, input logic [DW-1:0] b);
    row_t r;
    r[0] = a;
    r[1] = b;
    return r;
  endfunction

  function automatic row_t rnd_row();
    row_t r;
    for (int j = 0; j < M; j++) r[j] = $urandom;
    return r;
  endfunction

  // One clock cycle of stimulus; column j carries the row issued j cycles earlier.
  task automatic step(input logic iv, input row_t r, input logic rdy,
                      input logic rst_v, input logic en_v);
    @(posedge clk);
    #1;
    cyc++;
    reset     = rst_v;
    enable    = en_v;
    in_valid  = iv;
    out_ready = rdy;
    if (iv) begin
      issued[cyc] = r;
      pending.push_back('{ac: cyc + M - 1, r: r});
    end
    for (int j = 0; j < M; j++) begin
      if (issued.exists(cyc - j)) data_in[j] = issued[cyc - j][j];
      else data_in[j] = $urandom;
    end
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) step(1'b0, '0, rdy, 1'b1, 1'b1);
  endtask

  task automatic model_clear();
    mq.delete();
    pending.delete();
    issued.delete();
    movf = 1'b0;
  endtask

  // Monitor and reference model, sampled mid-cycle.
  always @(negedge clk) begin
    logic pop_m;
    logic al;
    row_t ar;
    if (!reset) model_clear();

    checks++;
    if (out_valid !== (mq.size() != 0)) begin
      failures++;
      $display("FAIL out_valid cyc=%0d got=%b exp=%b", cyc, out_valid, mq.size() != 0);
    end
    checks++;
    if (int'(count) != mq.size() || $isunknown(count)) begin
      failures++;
      $display("FAIL count cyc=%0d got=%0d exp=%0d", cyc, count, mq.size());
    end
    checks++;
    if (overflow !== movf) begin
      failures++;
      $display("FAIL overflow cyc=%0d got=%b exp=%b", cyc, overflow, movf);
    end
    checks++;
    if (mq.size() != 0) begin
      if (out_data !== mq[0]) begin
        failures++;
        $display("FAIL out_data cyc=%0d got=%h exp=%h", cyc, out_data, mq[0]);
      end
    end else if (out_data !== '0) begin
      failures++;
      $display("FAIL out_data_idle cyc=%0d got=%h exp=0", cyc, out_data);
    end

    if (reset) begin
      if (!enable) begin
        model_clear();
      end else begin
        pop_m = (mq.size() != 0) && out_ready;
        al    = (pending.size() != 0) && (pending[0].ac == cyc);
        ar    = '0;
        if (al) ar = pending.pop_front().r;
        if (pop_m) void'(mq.pop_front());
        if (al) begin
          if (mq.size() < DP) mq.push_back(ar);
          else movf = 1'b1;
        end
      end
    end
  end

  initial begin
    idle(0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    idle(2, 1'b1);

    // Single row {5,7}
    step(1'b1, mk(32'd5, 32'd7), 1'b1, 1'b1, 1'b1);
    idle(4, 1'b1);

    // Streaming four rows
    for (int i = 0; i < 4; i++) step(1'b1, mk(2*i + 1, 2*i + 2), 1'b1, 1'b1, 1'b1);
    idle(5, 1'b1);

    // Fill with five rows, fifth dropped, then drain
    for (int i = 0; i < 5; i++) step(1'b1, mk(32'h100 + i, 32'h200 + i), 1'b0, 1'b1, 1'b1);
    idle(3, 1'b0);
    idle(6, 1'b1);

    // Clear sticky overflow, then push into a full FIFO while popping
    step(1'b0, '0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, mk(32'h300 + i, 32'h400 + i), 1'b0, 1'b1, 1'b1);
    idle(2, 1'b0);
    step(1'b1, mk(32'h555, 32'h666), 1'b0, 1'b1, 1'b1);
    step(1'b0, '0, 1'b1, 1'b1, 1'b1);
    idle(2, 1'b0);
    idle(6, 1'b1);

    // Wrap-around with toggling ready
    for (int i = 0; i < 10; i++) step(1'b1, mk(32'h700 + i, 32'h800 + i), (i % 2) == 0, 1'b1, 1'b1);
    for (int i = 0; i < 12; i++) step(1'b0, '0, (i % 2) == 0, 1'b1, 1'b1);

    // Reset with two rows stored and one in flight
    for (int i = 0; i < 2; i++) step(1'b1, rnd_row(), 1'b0, 1'b1, 1'b1);
    idle(2, 1'b0);
    step(1'b1, rnd_row(), 1'b0, 1'b1, 1'b1);
    step(1'b0, '0, 1'b1, 1'b0, 1'b1);
    idle(5, 1'b1);

    // Same scenario with a one-edge enable drop
    for (int i = 0; i < 2; i++) step(1'b1, rnd_row(), 1'b0, 1'b1, 1'b1);
    idle(2, 1'b0);
    step(1'b1, rnd_row(), 1'b0, 1'b1, 1'b1);
    step(1'b0, '0, 1'b1, 1'b1, 1'b0);
    idle(5, 1'b1);

    // Randomised traffic with occasional clears
    for (int i = 0; i < 2000; i++) begin
      logic iv;
      logic rdy;
      logic en;
      iv  = ($urandom_range(0, 99) < 60);
      rdy = ($urandom_range(0, 99) < 45);
      en  = ($urandom_range(0, 199) != 0);
      step(iv, rnd_row(), rdy, 1'b1, en);
    end
    idle(12, 1'b1);

    @(posedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
